// File: rtl/fifo_param_status_if.sv
// fifo_param_status_if: push/pop, flag-clear and status bundle for the parametrised FIFO.
interface fifo_param_status_if #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);
  logic             flush;
  logic [WIDTH-1:0] wr_data;
  logic             wr_request;
  logic [WIDTH-1:0] rd_data;
  logic             rd_request;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  logic             clear_overflow_request;
  logic             clear_underflow_request;
  logic [AW:0]      threshold;
  logic             at_threshold;
  logic [AW:0]      level;
  logic [AW:0]      wr_index;
  logic [AW:0]      rd_index;
  modport master (
    output flush, wr_data, wr_request, rd_request,
           clear_overflow_request, clear_underflow_request, threshold,
    input  rd_data, empty, full, overflow, underflow, at_threshold,
           level, wr_index, rd_index
  );
  modport slave (
    input  flush, wr_data, wr_request, rd_request,
           clear_overflow_request, clear_underflow_request, threshold,
    output rd_data, empty, full, overflow, underflow, at_threshold,
           level, wr_index, rd_index
  );
endinterface

// File: rtl/fifo_param_status.sv
// fifo_param_status: show-ahead single-clock FIFO with pass-through on full,
// sticky overflow/underflow flags, level threshold and synchronous flush.
module fifo_param_status #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input logic                clk,
  input logic                reset,
  fifo_param_status_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_param_status: DEPTH must be a power of two >= 2");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_index_q, wr_index_d, rd_index_q, rd_index_d, level;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             empty, full, push_ok, pop_ok, ov_set, un_set;
  always_comb begin
    level       = wr_index_q - rd_index_q;
    empty       = level == '0;
    full        = level == FULL_LEVEL;
    // a pop while full frees the slot the simultaneous push lands in
    pop_ok      = !bus.flush && bus.rd_request && !empty;
    push_ok     = !bus.flush && bus.wr_request && (!full || bus.rd_request);
    ov_set      = !bus.flush && bus.wr_request && !push_ok;
    un_set      = !bus.flush && bus.rd_request && empty;
    overflow_d  = ov_set || (overflow_q && !bus.clear_overflow_request);
    underflow_d = un_set || (underflow_q && !bus.clear_underflow_request);
    wr_index_d  = bus.flush ? '0 : wr_index_q + (AW+1)'(push_ok);
    rd_index_d  = bus.flush ? '0 : rd_index_q + (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_index_q  <= '0;
      rd_index_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_index_q  <= wr_index_d;
      rd_index_q  <= rd_index_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_index_q[AW-1:0]] <= bus.wr_data;
  end
  assign bus.rd_data      = empty ? '0 : mem[rd_index_q[AW-1:0]];
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.at_threshold = level >= bus.threshold;
  assign bus.level        = level;
  assign bus.wr_index     = wr_index_q;
  assign bus.rd_index     = rd_index_q;
endmodule
